// File: rtl/sevenseg_pkg.sv
// Shared types and constants for the game shot-clock / score display.
package sevenseg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int unsigned DIG_W = 2;
    localparam int unsigned BCD_W = 4;
    localparam int unsigned SEG_W = 7;
    localparam int unsigned AN_W  = 4;

    localparam logic [DIG_W-1:0] DIG_TIME_ONES  = 2'd0;
    localparam logic [DIG_W-1:0] DIG_TIME_TENS  = 2'd1;
    localparam logic [DIG_W-1:0] DIG_SCORE_ONES = 2'd2;
    localparam logic [DIG_W-1:0] DIG_SCORE_TENS = 2'd3;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
    localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
    localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
    localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
    localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
    localparam logic [SEG_W-1:0] SEG_DASH  = 7'b0111111;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/sevenseg_decoder.sv
// Combinational BCD to active-low seven-segment decoder; non-BCD codes show a dash.
module sevenseg_decoder
    import sevenseg_pkg::*;
(
    input  logic [BCD_W-1:0] i_bcd,
    output logic [SEG_W-1:0] o_seg
);

    always_comb begin
        o_seg = SEG_DASH;
        case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/sevenseg_game_display.sv
// Shot-clock countdown, BCD score and 4-digit multiplexed common-anode display.
// Optional build macro SEVENSEG_BLANK_EN blanks tens digits that read zero.
module sevenseg_game_display
    import sevenseg_pkg::*;
#(
    parameter int unsigned START_SECS = 30
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_1hz,
    input  logic             scan_en,
    input  logic             start,
    input  logic             pause,
    input  logic             score_inc,
    output logic [AN_W-1:0]  an,
    output logic [SEG_W-1:0] seg,
    output logic             dp,
    output logic             time_up,
    output logic             running
);

    localparam logic [BCD_W-1:0] START_TENS = BCD_W'(START_SECS / 10);
    localparam logic [BCD_W-1:0] START_ONES = BCD_W'(START_SECS % 10);

    state_t           r_state;
    logic [BCD_W-1:0] r_time_tens, r_time_ones;
    logic [BCD_W-1:0] r_score_tens, r_score_ones;
    logic [DIG_W-1:0] r_idx;
    logic [AN_W-1:0]  r_an;
    logic [SEG_W-1:0] r_seg;
    logic             r_dp, r_time_up, r_running;

    logic [BCD_W-1:0] w_time_tens_dec, w_time_ones_dec;
    logic [BCD_W-1:0] w_score_tens_inc, w_score_ones_inc;
    logic             w_time_is_one;
    logic [BCD_W-1:0] w_digit;
    logic [SEG_W-1:0] w_dec_seg;
    logic             w_blank;

    // BCD decrement with borrow
    always_comb begin
        w_time_ones_dec = r_time_ones - 4'd1;
        w_time_tens_dec = r_time_tens;
        if (r_time_ones == 4'd0) begin
            w_time_ones_dec = 4'd9;
            w_time_tens_dec = r_time_tens - 4'd1;
        end
    end

    // BCD increment with carry, saturating at 99
    always_comb begin
        w_score_ones_inc = r_score_ones + 4'd1;
        w_score_tens_inc = r_score_tens;
        if (r_score_tens == 4'd9 && r_score_ones == 4'd9) begin
            w_score_ones_inc = r_score_ones;
        end else if (r_score_ones == 4'd9) begin
            w_score_ones_inc = 4'd0;
            w_score_tens_inc = r_score_tens + 4'd1;
        end
    end

    assign w_time_is_one = (r_time_tens == 4'd0) && (r_time_ones == 4'd1);

    always_comb begin
        w_digit = r_time_ones;
        case (r_idx)
            DIG_TIME_ONES:  w_digit = r_time_ones;
            DIG_TIME_TENS:  w_digit = r_time_tens;
            DIG_SCORE_ONES: w_digit = r_score_ones;
            DIG_SCORE_TENS: w_digit = r_score_tens;
            default:        w_digit = r_time_ones;
        endcase
    end

`ifdef SEVENSEG_BLANK_EN
    assign w_blank = ((r_idx == DIG_TIME_TENS) || (r_idx == DIG_SCORE_TENS)) && (w_digit == 4'd0);
`else
    assign w_blank = 1'b0;
`endif

    sevenseg_decoder u_decoder (
        .i_bcd (w_digit),
        .o_seg (w_dec_seg)
    );

    // FSM, counters, scan index and registered display outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_time_tens  <= START_TENS;
            r_time_ones  <= START_ONES;
            r_score_tens <= 4'd0;
            r_score_ones <= 4'd0;
            r_idx        <= DIG_TIME_ONES;
            r_an         <= 4'b1111;
            r_seg        <= SEG_BLANK;
            r_dp         <= 1'b1;
            r_time_up    <= 1'b0;
            r_running    <= 1'b0;
        end else begin
            r_time_up <= 1'b0;
            if (start) begin
                r_time_tens  <= START_TENS;
                r_time_ones  <= START_ONES;
                r_score_tens <= 4'd0;
                r_score_ones <= 4'd0;
                r_state      <= ST_RUN;
            end else if (pause) begin
                if (r_state == ST_RUN) begin
                    r_state <= ST_PAUSED;
                end else if (r_state == ST_PAUSED) begin
                    r_state <= ST_RUN;
                end
            end else if (r_state == ST_RUN) begin
                if (score_inc) begin
                    r_score_tens <= w_score_tens_inc;
                    r_score_ones <= w_score_ones_inc;
                end
                if (tick_1hz) begin
                    r_time_tens <= w_time_tens_dec;
                    r_time_ones <= w_time_ones_dec;
                    if (w_time_is_one) begin
                        r_state   <= ST_DONE;
                        r_time_up <= 1'b1;
                    end
                end
            end

            if (scan_en) begin
                r_idx <= r_idx + 2'd1;
            end

            r_an      <= ~(4'b0001 << r_idx);
            r_seg     <= w_blank ? SEG_BLANK : w_dec_seg;
            r_dp      <= (r_idx != DIG_SCORE_ONES);
            r_running <= (r_state == ST_RUN);
        end
    end

    assign an      = r_an;
    assign seg     = r_seg;
    assign dp      = r_dp;
    assign time_up = r_time_up;
    assign running = r_running;

endmodule

// File: tb/tb_sevenseg_game_display.sv
// Bench for sevenseg_game_display: integer-level game model checked every cycle plus literal pins.
module tb_sevenseg_game_display;

    localparam int unsigned START = 30;
`ifdef SEVENSEG_BLANK_EN
    localparam logic [6:0] TENS_ZERO = 7'h7F;
`else
    localparam logic [6:0] TENS_ZERO = 7'h40;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick_1hz = 1'b0, scan_en = 1'b0, start = 1'b0, pause = 1'b0, score_inc = 1'b0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp, time_up, running;

    always #5 clk = ~clk;

    sevenseg_game_display #(.START_SECS(START)) dut (
        .clk       (clk),
        .rst       (rst),
        .tick_1hz  (tick_1hz),
        .scan_en   (scan_en),
        .start     (start),
        .pause     (pause),
        .score_inc (score_inc),
        .an        (an),
        .seg       (seg),
        .dp        (dp),
        .time_up   (time_up),
        .running   (running)
    );

    // Segment table {g..a}, active-low, digits 0..9
    logic [6:0] pat [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    // Model: state 0 idle, 1 run, 2 paused, 3 done; time and score as plain integers
    int         m_time, m_score, m_state, m_idx;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp, e_tu, e_run;

    function automatic int digit_val(int idx, int t, int s);
        case (idx)
            0:       return t % 10;
            1:       return t / 10;
            2:       return s % 10;
            default: return s / 10;
        endcase
    endfunction

    always @(posedge clk) begin
        int d;
        if (rst) begin
            m_time = START; m_score = 0; m_state = 0; m_idx = 0;
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_tu = 1'b0; e_run = 1'b0;
        end else begin
            d     = digit_val(m_idx, m_time, m_score);
            e_an  = 4'hF;
            e_an[m_idx] = 1'b0;
            e_seg = pat[d];
`ifdef SEVENSEG_BLANK_EN
            if ((m_idx == 1 || m_idx == 3) && d == 0) e_seg = 7'h7F;
`endif
            e_dp  = (m_idx != 2);
            e_run = (m_state == 1);
            e_tu  = 1'b0;
            if (start) begin
                m_time = START; m_score = 0; m_state = 1;
            end else if (pause) begin
                if (m_state == 1) m_state = 2;
                else if (m_state == 2) m_state = 1;
            end else if (m_state == 1) begin
                if (score_inc && m_score < 99) m_score = m_score + 1;
                if (tick_1hz) begin
                    m_time = m_time - 1;
                    if (m_time == 0) begin
                        m_state = 3;
                        e_tu    = 1'b1;
                    end
                end
            end
            if (scan_en) m_idx = (m_idx + 1) % 4;
        end
    end

    int vectors = 0;
    int miscompares = 0;
    int tu_count = 0;

    task automatic lit(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic cycle_check();
        vectors++;
        if (time_up === 1'b1) tu_count++;
        if ({an, seg, dp, time_up, running} !== {e_an, e_seg, e_dp, e_tu, e_run}) begin
            miscompares++;
            $display("FAIL cycle @%0t: an=%b seg=%b dp=%b tu=%b run=%b expected an=%b seg=%b dp=%b tu=%b run=%b",
                     $time, an, seg, dp, time_up, running, e_an, e_seg, e_dp, e_tu, e_run);
        end
    endtask

    task automatic apply(input bit st, input bit ps, input bit tk, input bit si, input bit sc);
        start = st; pause = ps; tick_1hz = tk; score_inc = si; scan_en = sc;
        @(posedge clk);
        #1;
        start = 0; pause = 0; tick_1hz = 0; score_inc = 0; scan_en = 0;
        cycle_check();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply(0, 0, 0, 0, 0);
    endtask

    // Scan to digit d (at most 4 strobes), let the display register catch up, check the anode
    task automatic show_digit(input int d);
        logic [3:0] exp_an;
        for (int i = 0; i < 4 && m_idx != d; i++) apply(0, 0, 0, 0, 1);
        apply(0, 0, 0, 0, 0);
        exp_an = 4'hF;
        exp_an[d] = 1'b0;
        lit("show_an", int'(an), int'(exp_an));
    endtask

    initial begin
        rst = 1'b1;
        apply(0, 0, 0, 0, 0);
        apply(0, 0, 0, 0, 0);
        lit("reset_an", int'(an), 'hF);
        lit("reset_seg", int'(seg), 'h7F);
        lit("reset_dp", int'(dp), 1);
        lit("reset_running", int'(running), 0);
        rst = 1'b0;

        // Scan walk after reset: digits 0,3,0,0
        apply(0, 0, 0, 0, 0);
        lit("scan0_an", int'(an), 'hE);
        lit("scan0_seg", int'(seg), 'h40);
        apply(0, 0, 0, 0, 1); apply(0, 0, 0, 0, 0);
        lit("scan1_an", int'(an), 'hD);
        lit("scan1_seg", int'(seg), 'h30);
        lit("scan1_dp", int'(dp), 1);
        apply(0, 0, 0, 0, 1); apply(0, 0, 0, 0, 0);
        lit("scan2_an", int'(an), 'hB);
        lit("scan2_dp", int'(dp), 0);
        apply(0, 0, 0, 0, 1); apply(0, 0, 0, 0, 0);
        lit("scan3_an", int'(an), 'h7);
        lit("scan3_seg", int'(seg), int'(TENS_ZERO));
        lit("scan3_dp", int'(dp), 1);

        // Full countdown
        apply(1, 0, 0, 0, 0);
        tu_count = 0;
        for (int i = 0; i < 29; i++) apply(0, 0, 1, 0, i % 2 == 0);
        lit("model_time_01", m_time, 1);
        apply(0, 0, 1, 0, 0);
        lit("time_up_pulse", int'(time_up), 1);
        apply(0, 0, 0, 0, 0);
        lit("time_up_clear", int'(time_up), 0);
        lit("running_low", int'(running), 0);
        for (int i = 0; i < 3; i++) apply(0, 1, 1, 1, 1);
        lit("done_time_held", m_time, 0);
        lit("done_score_held", m_score, 0);
        lit("time_up_count", tu_count, 1);
        show_digit(0);
        lit("done_ones_seg", int'(seg), 'h40);

        // Score carry and saturation
        apply(1, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) apply(0, 0, 0, 1, 1);
        lit("model_score_09", m_score, 9);
        apply(0, 0, 0, 1, 1);
        lit("model_score_10", m_score, 10);
        show_digit(3);
        lit("score_tens_1", int'(seg), 'h79);
        show_digit(2);
        lit("score_ones_0", int'(seg), 'h40);
        for (int i = 0; i < 91; i++) apply(0, 0, 0, 1, 1);
        lit("model_score_99", m_score, 99);
        show_digit(3);
        lit("score_tens_9", int'(seg), 'h10);
        show_digit(2);
        lit("score_ones_9", int'(seg), 'h10);

        // Pause holds time
        apply(1, 0, 0, 0, 0);
        for (int i = 0; i < 13; i++) apply(0, 0, 1, 0, 0);
        lit("model_time_17", m_time, 17);
        apply(0, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) apply(0, 0, 1, 1, 1);
        lit("paused_time_17", m_time, 17);
        lit("paused_running", int'(running), 0);
        show_digit(1);
        lit("paused_tens_1", int'(seg), 'h79);
        show_digit(0);
        lit("paused_ones_7", int'(seg), 'h78);
        apply(0, 1, 0, 0, 0);
        apply(0, 0, 1, 0, 0);
        lit("resumed_time_16", m_time, 16);
        show_digit(0);
        lit("resumed_ones_6", int'(seg), 'h02);

        // Start beats tick while running
        apply(1, 0, 0, 0, 0);
        for (int i = 0; i < 18; i++) apply(0, 0, 1, 0, 0);
        for (int i = 0; i < 40; i++) apply(0, 0, 0, 1, 1);
        lit("model_12_40", m_time * 100 + m_score, 1240);
        apply(1, 0, 1, 0, 0);
        lit("restart_model", m_time * 100 + m_score, 3000);
        lit("restart_state", m_state, 1);
        apply(0, 0, 0, 0, 0);
        lit("restart_running", int'(running), 1);
        show_digit(1);
        lit("restart_tens_3", int'(seg), 'h30);
        show_digit(3);
        lit("restart_score_tens", int'(seg), int'(TENS_ZERO));
        apply(0, 0, 1, 1, 0);
        lit("tick_and_inc", m_time * 100 + m_score, 2901);
        show_digit(2);
        lit("inc_ones_1", int'(seg), 'h79);

        // Leading-zero score tens
        apply(1, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) apply(0, 0, 0, 1, 0);
        show_digit(3);
        lit("score07_tens", int'(seg), int'(TENS_ZERO));
        lit("score07_dp", int'(dp), 1);
        show_digit(2);
        lit("score07_ones", int'(seg), 'h78);

        // Mid-game reset overrides inputs
        rst = 1'b1;
        apply(1, 0, 1, 1, 1);
        lit("midreset_an", int'(an), 'hF);
        lit("midreset_seg", int'(seg), 'h7F);
        rst = 1'b0;
        apply(0, 0, 0, 0, 0);
        idle(1);
        lit("postreset_an", int'(an), 'hE);
        lit("postreset_seg", int'(seg), 'h40);
        lit("postreset_running", int'(running), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
